// File: rtl/battleship_game_ctrl.sv
// Battleship game controller: validates shots, drives the shared cell scorer
// one cell per cycle, and keeps the hit map, counters and win/loss status.
module battleship_game_ctrl #(
  parameter int unsigned NUM_SHOTS  = 20,
  parameter int unsigned NUM_BIG    = 2,
  parameter int unsigned SHIP_CELLS = 19
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       NewGame,
  input  logic       ShotValid,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Big,
  output logic       ProbeValid,
  output logic [3:0] ProbeX,
  output logic [3:0] ProbeY,
  input  logic       ProbeHit,
  input  logic       ProbeNearMiss,
  input  logic [4:0] ProbeShip,
  output logic       Busy,
  output logic       ShotDone,
  output logic [3:0] ShotHits,
  output logic       ShotNearMiss,
  output logic       ShotMiss,
  output logic       SomethingIsWrong,
  output logic [4:0] TotalHits,
  output logic [4:0] ShotsLeft,
  output logic [1:0] BigLeft,
  output logic [4:0] BiggestShipHit,
  output logic       GameOver,
  output logic       Won
);

  localparam logic [4:0] SHOTS_INIT = 5'(NUM_SHOTS);
  localparam logic [1:0] BIG_INIT   = 2'(NUM_BIG);
  localparam logic [4:0] SHIP_TOTAL = 5'(SHIP_CELLS);

  typedef enum logic [2:0] {IDLE, READY, PROBE, DONE, OVER} state_t;
  state_t state, state_nx;

  logic [99:0] hitmap;
  logic [3:0]  lx, ly;
  logic        lbig;
  logic [1:0]  col, row;
  logic [3:0]  hitcnt;
  logic        nearflag;

  logic [4:0]  px, py;
  logic        on_grid;
  logic [6:0]  pidx;
  logic        new_hit, last_probe, shot_ok;
  logic [3:0]  cnt_final;
  logic        near_final;

  // A normal shot starts at col=row=1 so the offset is zero and it ends after one probe.
  always_comb begin
    px         = {1'b0, lx} + {3'b000, col} - 5'd1;
    py         = {1'b0, ly} + {3'b000, row} - 5'd1;
    on_grid    = (state == PROBE) && (px >= 5'd1) && (px <= 5'd10)
                 && (py >= 5'd1) && (py <= 5'd10);
    pidx       = on_grid ? (7'(py) * 7'd10 + 7'(px) - 7'd11) : '0;
    new_hit    = on_grid && ProbeHit && !hitmap[pidx];
    cnt_final  = hitcnt + {3'b000, new_hit};
    near_final = nearflag | (on_grid & ProbeNearMiss);
    last_probe = !lbig || ((col == 2'd2) && (row == 2'd2));
    shot_ok    = (X >= 4'd1) && (X <= 4'd10) && (Y >= 4'd1) && (Y <= 4'd10)
                 && !(Big && (BigLeft == 2'd0));
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (NewGame) begin
      state_nx = READY;
    end else begin
      case (state)
        READY:   if (ShotValid) state_nx = shot_ok ? PROBE : DONE;
        PROBE:   if (last_probe) state_nx = DONE;
        DONE:    state_nx = ((TotalHits == SHIP_TOTAL) || (ShotsLeft == '0)) ? OVER : READY;
        default: state_nx = state;
      endcase
    end
    ProbeValid = on_grid;
    ProbeX     = on_grid ? px[3:0] : '0;
    ProbeY     = on_grid ? py[3:0] : '0;
    Busy       = (state == PROBE) || (state == DONE);
    ShotDone   = (state == DONE);
    GameOver   = (state == OVER);
    Won        = (state == OVER) && (TotalHits == SHIP_TOTAL);
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      hitmap           <= '0;
      lx               <= '0;
      ly               <= '0;
      lbig             <= 1'b0;
      col              <= '0;
      row              <= '0;
      hitcnt           <= '0;
      nearflag         <= 1'b0;
      ShotHits         <= '0;
      ShotNearMiss     <= 1'b0;
      ShotMiss         <= 1'b0;
      SomethingIsWrong <= 1'b0;
      TotalHits        <= '0;
      ShotsLeft        <= '0;
      BigLeft          <= '0;
      BiggestShipHit   <= '0;
    end else if (NewGame) begin
      hitmap           <= '0;
      ShotHits         <= '0;
      ShotNearMiss     <= 1'b0;
      ShotMiss         <= 1'b0;
      SomethingIsWrong <= 1'b0;
      TotalHits        <= '0;
      ShotsLeft        <= SHOTS_INIT;
      BigLeft          <= BIG_INIT;
      BiggestShipHit   <= '0;
    end else begin
      case (state)
        READY: begin
          if (ShotValid && shot_ok) begin
            lx       <= X;
            ly       <= Y;
            lbig     <= Big;
            col      <= Big ? 2'd0 : 2'd1;
            row      <= Big ? 2'd0 : 2'd1;
            hitcnt   <= '0;
            nearflag <= 1'b0;
          end else if (ShotValid) begin
            SomethingIsWrong <= 1'b1;
            ShotHits         <= '0;
            ShotNearMiss     <= 1'b0;
            ShotMiss         <= 1'b0;
          end
        end
        PROBE: begin
          if (new_hit) begin
            hitmap[pidx] <= 1'b1;
            if (ProbeShip > BiggestShipHit) BiggestShipHit <= ProbeShip;
          end
          hitcnt   <= cnt_final;
          nearflag <= near_final;
          if (last_probe) begin
            ShotHits         <= cnt_final;
            ShotNearMiss     <= (cnt_final == '0) && near_final;
            ShotMiss         <= (cnt_final == '0) && !near_final;
            SomethingIsWrong <= 1'b0;
            TotalHits        <= TotalHits + {1'b0, cnt_final};
            ShotsLeft        <= ShotsLeft - 5'd1;
            if (lbig) BigLeft <= BigLeft - 2'd1;
          end else if (col == 2'd2) begin
            col <= '0;
            row <= row + 2'd1;
          end else begin
            col <= col + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Self-checking bench for battleship_game_ctrl: a board-driven scorer, a
// queue-based game model compared every cycle, directed and random games.
module tb_battleship_game_ctrl;

  localparam int SHIPS = 19;

  logic       clock = 1'b0, reset_L = 1'b0, NewGame = 1'b0, ShotValid = 1'b0, Big = 1'b0;
  logic [3:0] X = '0, Y = '0;
  logic       ProbeValid, ProbeHit, ProbeNearMiss, Busy, ShotDone, ShotNearMiss, ShotMiss;
  logic       SomethingIsWrong, GameOver, Won;
  logic [3:0] ProbeX, ProbeY, ShotHits;
  logic [4:0] ProbeShip, TotalHits, ShotsLeft, BiggestShipHit;
  logic [1:0] BigLeft;

  always #5 clock = ~clock;

  battleship_game_ctrl #(.NUM_SHOTS(20), .NUM_BIG(2), .SHIP_CELLS(19)) dut (
    .clock(clock), .reset_L(reset_L), .NewGame(NewGame), .ShotValid(ShotValid),
    .X(X), .Y(Y), .Big(Big), .ProbeValid(ProbeValid), .ProbeX(ProbeX), .ProbeY(ProbeY),
    .ProbeHit(ProbeHit), .ProbeNearMiss(ProbeNearMiss), .ProbeShip(ProbeShip),
    .Busy(Busy), .ShotDone(ShotDone), .ShotHits(ShotHits), .ShotNearMiss(ShotNearMiss),
    .ShotMiss(ShotMiss), .SomethingIsWrong(SomethingIsWrong), .TotalHits(TotalHits),
    .ShotsLeft(ShotsLeft), .BigLeft(BigLeft), .BiggestShipHit(BiggestShipHit),
    .GameOver(GameOver), .Won(Won)
  );

  // Scorer: answers from the board; returns junk when the probe is not valid.
  logic [4:0] board [0:15][0:15];
  bit         nmap  [0:15][0:15];
  int         occ_x[$], occ_y[$];
  logic       junk = 1'b0;
  always @(posedge clock) junk <= ~junk;

  always_comb begin
    ProbeHit      = junk;
    ProbeNearMiss = ~junk;
    ProbeShip     = {5{junk}};
    if (ProbeValid) begin
      ProbeHit      = (board[ProbeX][ProbeY] != '0);
      ProbeNearMiss = nmap[ProbeX][ProbeY];
      ProbeShip     = board[ProbeX][ProbeY];
    end
  end

  int checks = 0, errors = 0;
  bit en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: a queue of cells still to probe plus plain counters.
  int  m_started, m_over, m_done, m_total, m_bsh, m_shots, m_big;
  int  m_hits, m_nm, m_miss, m_wrong, m_cnt, m_near, m_curbig;
  bit  m_map [0:15][0:15];
  int  mq_x[$], mq_y[$];
  int  fx, fy, sx, sy;

  function automatic bit on(input int x, input int y);
    return (x >= 1) && (x <= 10) && (y >= 1) && (y <= 10);
  endfunction

  task automatic m_clear(input bit newgame);
    m_started = newgame; m_over = 0; m_done = 0; m_total = 0; m_bsh = 0;
    m_shots = newgame ? 20 : 0; m_big = newgame ? 2 : 0;
    m_hits = 0; m_nm = 0; m_miss = 0; m_wrong = 0;
    mq_x.delete(); mq_y.delete();
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) m_map[i][j] = 1'b0;
  endtask

  initial forever begin
    @(posedge clock or negedge reset_L);
    if (!reset_L) m_clear(0);
    else if (NewGame) m_clear(1);
    else if (m_done != 0) begin
      m_done = 0;
      if (m_total == SHIPS || m_shots == 0) m_over = 1;
    end else if (mq_x.size() > 0) begin
      fx = mq_x.pop_front(); fy = mq_y.pop_front();
      if (on(fx, fy)) begin
        if (board[fx][fy] != '0 && !m_map[fx][fy]) begin
          m_map[fx][fy] = 1'b1;
          m_cnt++;
          if (int'(board[fx][fy]) > m_bsh) m_bsh = int'(board[fx][fy]);
        end
        if (nmap[fx][fy]) m_near = 1;
      end
      if (mq_x.size() == 0) begin
        m_hits = m_cnt; m_nm = (m_cnt == 0 && m_near != 0); m_miss = (m_cnt == 0 && m_near == 0);
        m_wrong = 0; m_total += m_cnt; m_shots--; if (m_curbig != 0) m_big--;
        m_done = 1;
      end
    end else if (m_started != 0 && m_over == 0 && ShotValid) begin
      sx = int'(X); sy = int'(Y);
      if (!on(sx, sy) || (Big && m_big == 0)) begin
        m_done = 1; m_wrong = 1; m_hits = 0; m_nm = 0; m_miss = 0;
      end else begin
        m_cnt = 0; m_near = 0; m_curbig = int'(Big);
        if (Big) begin
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin mq_x.push_back(sx + dx); mq_y.push_back(sy + dy); end
        end else begin
          mq_x.push_back(sx); mq_y.push_back(sy);
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (en) begin
      bit epv;
      epv = (mq_x.size() > 0) && on(mq_x[0], mq_y[0]);
      chk("ProbeValid", int'(ProbeValid), int'(epv));
      chk("ProbeX", int'(ProbeX), epv ? mq_x[0] : 0);
      chk("ProbeY", int'(ProbeY), epv ? mq_y[0] : 0);
      chk("Busy", int'(Busy), int'(mq_x.size() > 0 || m_done != 0));
      chk("ShotDone", int'(ShotDone), m_done);
      chk("ShotHits", int'(ShotHits), m_hits);
      chk("ShotNearMiss", int'(ShotNearMiss), m_nm);
      chk("ShotMiss", int'(ShotMiss), m_miss);
      chk("SomethingIsWrong", int'(SomethingIsWrong), m_wrong);
      chk("TotalHits", int'(TotalHits), m_total);
      chk("ShotsLeft", int'(ShotsLeft), m_shots);
      chk("BigLeft", int'(BigLeft), m_big);
      chk("BiggestShipHit", int'(BiggestShipHit), m_bsh);
      chk("GameOver", int'(GameOver), m_over);
      chk("Won", int'(Won), int'(m_over != 0 && m_total == SHIPS));
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin board[i][j] = '0; nmap[i][j] = 1'b0; end
    occ_x.delete(); occ_y.delete();
  endtask

  task automatic put(input int x, input int y, input logic [4:0] s);
    board[x][y] = s; occ_x.push_back(x); occ_y.push_back(y);
  endtask

  task automatic random_board();
    int x, y;
    clear_board();
    while (occ_x.size() < SHIPS) begin
      x = int'($urandom_range(1, 10)); y = int'($urandom_range(1, 10));
      if (board[x][y] == '0) put(x, y, 5'(1 << $urandom_range(0, 4)));
    end
    for (int i = 1; i <= 10; i++)
      for (int j = 1; j <= 10; j++) if (board[i][j] == '0) nmap[i][j] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic new_game();
    NewGame = 1'b1; @(posedge clock); #1; NewGame = 1'b0;
  endtask

  // Returns at the ShotDone cycle; lat counts cycles from the acceptance edge.
  task automatic fire(input int x, input int y, input bit big, output int lat, output int pvs);
    X = 4'(x); Y = 4'(y); Big = big; ShotValid = 1'b1;
    @(posedge clock); #1; ShotValid = 1'b0; Big = 1'b0;
    lat = 1; pvs = 0;
    while (!ShotDone && lat < 30) begin pvs += int'(ProbeValid); @(posedge clock); #1; lat++; end
    chk("shot_done_seen", int'(ShotDone), 1);
  endtask

  initial begin
    int lat, pvs, dn;
    clear_board();
    idle(2);
    #2 reset_L = 1'b1;
    idle(1);
    en = 1'b1;
    chk("rst_ShotsLeft", int'(ShotsLeft), 0);
    chk("rst_GameOver", int'(GameOver), 0);

    // Single-cell shots, repeats, near miss, miss, rejected coordinates.
    put(3, 3, 5'b10000); nmap[1][1] = 1'b1;
    new_game();
    chk("ng_ShotsLeft", int'(ShotsLeft), 20);
    chk("ng_BigLeft", int'(BigLeft), 2);
    chk("ng_TotalHits", int'(TotalHits), 0);
    chk("ng_Busy", int'(Busy), 0);
    fire(3, 3, 0, lat, pvs);
    chk("hit_latency", lat, 2); chk("hit_ShotHits", int'(ShotHits), 1);
    chk("hit_TotalHits", int'(TotalHits), 1); chk("hit_Biggest", int'(BiggestShipHit), 16);
    chk("hit_ShotsLeft", int'(ShotsLeft), 19);
    idle(1);
    fire(3, 3, 0, lat, pvs);
    chk("rehit_ShotHits", int'(ShotHits), 0); chk("rehit_ShotMiss", int'(ShotMiss), 1);
    chk("rehit_TotalHits", int'(TotalHits), 1); chk("rehit_ShotsLeft", int'(ShotsLeft), 18);
    idle(1);
    fire(1, 1, 0, lat, pvs);
    chk("near_ShotNearMiss", int'(ShotNearMiss), 1); chk("near_ShotHits", int'(ShotHits), 0);
    idle(1);
    nmap[1][1] = 1'b0;
    fire(1, 1, 0, lat, pvs);
    chk("miss_ShotMiss", int'(ShotMiss), 1); chk("miss_ShotsLeft", int'(ShotsLeft), 16);
    idle(1);
    fire(0, 5, 0, lat, pvs);
    chk("x0_latency", lat, 1); chk("x0_wrong", int'(SomethingIsWrong), 1);
    chk("x0_ShotsLeft", int'(ShotsLeft), 16);
    idle(1);
    fire(5, 11, 0, lat, pvs);
    chk("y11_wrong", int'(SomethingIsWrong), 1); chk("y11_ShotsLeft", int'(ShotsLeft), 16);
    idle(1);

    // Big bombs: full neighbourhood, corner clipping, no bombs left.
    clear_board();
    for (int y = 1; y <= 3; y++)
      for (int x = 2; x <= 4; x++) put(x, y, (x == 4 && y == 3) ? 5'b01000 : 5'b00100);
    new_game();
    fire(3, 2, 1, lat, pvs);
    chk("big_latency", lat, 10); chk("big_ShotHits", int'(ShotHits), 9);
    chk("big_BigLeft", int'(BigLeft), 1); chk("big_ShotsLeft", int'(ShotsLeft), 19);
    chk("big_Biggest", int'(BiggestShipHit), 8);
    idle(1);
    fire(1, 1, 1, lat, pvs);
    chk("corner_latency", lat, 10); chk("corner_probes", pvs, 4);
    chk("corner_ShotHits", int'(ShotHits), 0); chk("corner_BigLeft", int'(BigLeft), 0);
    idle(1);
    fire(5, 5, 1, lat, pvs);
    chk("nobig_wrong", int'(SomethingIsWrong), 1); chk("nobig_BigLeft", int'(BigLeft), 0);
    chk("nobig_ShotsLeft", int'(ShotsLeft), 18);
    idle(1);

    // NewGame while a big bomb is probing.
    new_game();
    X = 4'd6; Y = 4'd6; Big = 1'b1; ShotValid = 1'b1;
    @(posedge clock); #1; ShotValid = 1'b0; Big = 1'b0;
    idle(4);
    NewGame = 1'b1; @(posedge clock); #1; NewGame = 1'b0;
    chk("abort_Busy", int'(Busy), 0); chk("abort_ShotsLeft", int'(ShotsLeft), 20);
    chk("abort_BigLeft", int'(BigLeft), 2);
    dn = 0;
    repeat (12) begin dn += int'(ShotDone); idle(1); end
    chk("abort_no_done", dn, 0);

    // Run out of shots with no hits, then shots must be ignored.
    clear_board();
    new_game();
    for (int i = 0; i < 20; i++) begin fire(5, 5, 0, lat, pvs); idle(1); end
    chk("lose_GameOver", int'(GameOver), 1); chk("lose_Won", int'(Won), 0);
    ShotValid = 1'b1; X = 4'd2; Y = 4'd2;
    dn = 0;
    repeat (5) begin idle(1); dn += int'(ShotDone); end
    ShotValid = 1'b0;
    chk("over_ignored", dn, 0);

    // Hit every ship cell.
    random_board();
    new_game();
    for (int i = 0; i < SHIPS; i++) begin fire(occ_x[i], occ_y[i], 0, lat, pvs); idle(1); end
    chk("win_GameOver", int'(GameOver), 1); chk("win_Won", int'(Won), 1);
    chk("win_TotalHits", int'(TotalHits), 19); chk("win_ShotsLeft", int'(ShotsLeft), 1);

    // Asynchronous reset in the middle of a big bomb.
    new_game();
    X = 4'd3; Y = 4'd3; Big = 1'b1; ShotValid = 1'b1;
    @(posedge clock); #1; ShotValid = 1'b0; Big = 1'b0;
    idle(3);
    #3 reset_L = 1'b0;
    #1;
    chk("arst_ProbeValid", int'(ProbeValid), 0); chk("arst_Busy", int'(Busy), 0);
    chk("arst_ShotsLeft", int'(ShotsLeft), 0); chk("arst_TotalHits", int'(TotalHits), 0);
    @(posedge clock); #3 reset_L = 1'b1;
    @(posedge clock); #1;
    ShotValid = 1'b1; X = 4'd4; Y = 4'd4; idle(2); ShotValid = 1'b0;

    // Random games with free-running, unsynchronised requests.
    for (int g = 0; g < 8; g++) begin
      random_board();
      new_game();
      for (int c = 0; c < 300; c++) begin
        int r, k;
        NewGame   = ($urandom_range(0, 299) == 0);
        ShotValid = ($urandom_range(0, 2) == 0);
        Big       = ($urandom_range(0, 5) == 0);
        r = int'($urandom_range(0, 9));
        if (r < 5) begin
          k = int'($urandom_range(0, SHIPS - 1)); X = 4'(occ_x[k]); Y = 4'(occ_y[k]);
        end else if (r < 9) begin
          X = 4'($urandom_range(1, 10)); Y = 4'($urandom_range(1, 10));
        end else begin
          X = 4'($urandom_range(0, 15)); Y = 4'($urandom_range(0, 15));
        end
        idle(1);
      end
      NewGame = 1'b0; ShotValid = 1'b0; Big = 1'b0;
      idle(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
